// File: rtl/fp_add_req_arbiter.sv
// ---------------------------------------------------------------------------
// fp_add_req_arbiter
//
// Shares one pipelined FP adder between two requesters. A round-robin
// arbiter picks at most one operand pair per cycle, the pair is registered
// into the adder, and a tag pipe that tracks the adder latency remembers
// which port issued each operation so that the result can be routed back.
// Operand and result bits pass through untouched; all floating-point work
// happens inside the adder.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/a/b, req0_ready  requester 0 handshake (ready = grant)
//   req1_valid/a/b, req1_ready  requester 1 handshake (ready = grant)
//   add_in_valid, add_a/add_b   registered issue to the adder
//   add_out_valid, add_result   result coming back from the adder
//   rsp0_valid, rsp1_valid      one-cycle result pulse per requester
//   rsp_data                    result data, qualified by rsp*_valid
//   busy                        any operation in flight
//   tag_err                     sticky: adder strobe disagreed with tag pipe
// ---------------------------------------------------------------------------
module fp_add_req_arbiter #(
    parameter int W        = 32,
    parameter int PIPE_LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         add_in_valid,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic         add_out_valid,
    input  logic [W-1:0] add_result,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp_data,
    output logic         busy,
    output logic         tag_err
);

    localparam int CW = $clog2(PIPE_LAT + 1);

    // r_ptr = 0: port 0 wins a tie; r_ptr = 1: port 1 wins a tie.
    logic                r_ptr;
    // Requester ID of the operation currently on add_in_valid.
    logic                r_id_p0;
    // Tag pipe: index 0 is one cycle behind add_in_valid, the last index
    // lines up with add_out_valid.
    logic [PIPE_LAT-1:0] r_tag_vld;
    logic [PIPE_LAT-1:0] r_tag_id;
    // Counts down the cycles after reset during which results of flushed
    // operations may still emerge from the adder.
    logic [CW-1:0]       r_flush_cnt;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_out_vld;
    logic                w_out_id;
    logic                w_flush_act;

    always_comb begin
        w_gnt0      = !rst && req0_valid && (!req1_valid || !r_ptr);
        w_gnt1      = !rst && req1_valid && (!req0_valid ||  r_ptr);
        w_out_vld   = r_tag_vld[PIPE_LAT-1] && !rst;
        w_out_id    = r_tag_id[PIPE_LAT-1];
        w_flush_act = (r_flush_cnt != '0);
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Response routing is combinational so the pulse lands in the same
    // cycle as the adder strobe. A missing strobe with a live tag still
    // pulses; a strobe without a tag is dropped.
    assign rsp0_valid = w_out_vld && !w_out_id;
    assign rsp1_valid = w_out_vld &&  w_out_id;
    assign rsp_data   = w_out_vld ? add_result : '0;

    assign busy = (|r_tag_vld) || add_in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= 1'b0;
            add_in_valid <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
            r_id_p0      <= 1'b0;
            r_tag_vld    <= '0;
            r_tag_id     <= '0;
            tag_err      <= 1'b0;
            r_flush_cnt  <= CW'(PIPE_LAT);
        end else begin
            // Arbitration / issue stage
            if (w_gnt0) begin
                r_ptr <= 1'b1;
            end else if (w_gnt1) begin
                r_ptr <= 1'b0;
            end

            add_in_valid <= w_gnt0 || w_gnt1;
            if (w_gnt0) begin
                add_a   <= req0_a;
                add_b   <= req0_b;
                r_id_p0 <= 1'b0;
            end else if (w_gnt1) begin
                add_a   <= req1_a;
                add_b   <= req1_b;
                r_id_p0 <= 1'b1;
            end

            // Tag pipe stages
            r_tag_vld[0] <= add_in_valid;
            r_tag_id[0]  <= r_id_p0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end

            // Result check stage: no tag can legitimately reach the output
            // during the flush window, so strobes there belong to operations
            // killed by reset and are ignored.
            if (w_flush_act) begin
                r_flush_cnt <= r_flush_cnt - CW'(1);
            end
            if (!w_flush_act && (add_out_valid != r_tag_vld[PIPE_LAT-1])) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule
